// File: rtl/mips_check_pkg.sv
// Shared definitions for the MIPS store-bus self-check monitor:
// checker state encoding and the store-compare modes.
package mips_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  // ORDERED: any wrong store ends the test. LOOSE: wrong stores are only counted.
  typedef enum logic {
    MODE_ORDERED = 1'b0,
    MODE_LOOSE   = 1'b1
  } mode_e;

endpackage

// File: rtl/memwrite_expect_table.sv
// Expected-store table: NUM_TESTS slots of SEQ_DEPTH {last,addr,data} entries.
// One synchronous write port, one asynchronous read port. Contents survive reset.
module memwrite_expect_table #(
  parameter int unsigned NUM_TESTS = 5,
  parameter int unsigned SEQ_DEPTH = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(NUM_TESTS)-1:0] wr_test_i,
  input  logic [$clog2(SEQ_DEPTH)-1:0] wr_idx_i,
  input  logic                         wr_last_i,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [DATA_W-1:0]            wr_data_i,
  input  logic [$clog2(NUM_TESTS)-1:0] rd_test_i,
  input  logic [$clog2(SEQ_DEPTH)-1:0] rd_idx_i,
  output logic                         rd_last_o,
  output logic [ADDR_W-1:0]            rd_addr_o,
  output logic [DATA_W-1:0]            rd_data_o
);

  localparam int unsigned TW    = $clog2(NUM_TESTS);
  localparam int unsigned IW    = $clog2(SEQ_DEPTH);
  localparam int unsigned DEPTH = NUM_TESTS * SEQ_DEPTH;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned EW    = 1 + ADDR_W + DATA_W;

  // Flatten (test, index) into a linear entry number.
  function automatic logic [AW-1:0] entry_num(input logic [TW-1:0] t, input logic [IW-1:0] i);
    logic [31:0] lin;
    lin = 32'(t) * SEQ_DEPTH + 32'(i);
    return lin[AW-1:0];
  endfunction

  logic [EW-1:0] mem_q [DEPTH];
  logic          wr_ok;
  logic          rd_ok;
  logic [EW-1:0] rd_word;

  // Slots beyond NUM_TESTS do not exist: such writes are dropped, reads return 0.
  assign wr_ok = we_i && (32'(wr_test_i) < NUM_TESTS);
  assign rd_ok = 32'(rd_test_i) < NUM_TESTS;

  // Table write port.
  // NOTE: storage arrays carry no reset (contents must survive it) and, like all
  // sequential state, are written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[entry_num(wr_test_i, wr_idx_i)] <= {wr_last_i, wr_addr_i, wr_data_i};
    end
  end

  assign rd_word = rd_ok ? mem_q[entry_num(rd_test_i, rd_idx_i)] : '0;
  assign {rd_last_o, rd_addr_o, rd_data_o} = rd_word;

endmodule

// File: rtl/memwrite_checker.sv
// Self-check monitor for the MIPS data-memory write bus. Runs one table slot
// at a time, matching observed stores against the expected sequence, and
// reports pass/fail, cycles spent, mismatch count and the first bad store.
module memwrite_checker
  import mips_check_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 5,
  parameter int unsigned SEQ_DEPTH = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         memwrite,
  input  logic [ADDR_W-1:0]            dataadr,
  input  logic [DATA_W-1:0]            writedata,
  input  logic                         mode,
  input  logic                         start,
  input  logic [$clog2(NUM_TESTS)-1:0] test_sel,
  input  logic                         exp_we,
  input  logic [$clog2(NUM_TESTS)-1:0] exp_test,
  input  logic [$clog2(SEQ_DEPTH)-1:0] exp_idx,
  input  logic [ADDR_W-1:0]            exp_addr,
  input  logic [DATA_W-1:0]            exp_data,
  input  logic                         exp_last,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timed_out,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [CNT_W-1:0]             err_count,
  output logic [ADDR_W-1:0]            bad_addr,
  output logic [DATA_W-1:0]            bad_data
);

  localparam int unsigned TW = $clog2(NUM_TESTS);
  localparam int unsigned IW = $clog2(SEQ_DEPTH);

  state_e            state_q;
  mode_e             mode_q;
  logic [TW-1:0]     test_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     ptr_d;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  cycle_d;
  logic [CNT_W-1:0]  err_q;
  logic [CNT_W-1:0]  err_d;
  logic [ADDR_W-1:0] bad_addr_q;
  logic [DATA_W-1:0] bad_data_q;
  logic              bad_seen_q;
  logic              timed_out_q;

  logic              ent_last;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
  logic              hit;
  logic              miss;
  logic              final_entry;
  logic              complete;
  logic              expire;

  memwrite_expect_table #(
    .NUM_TESTS (NUM_TESTS),
    .SEQ_DEPTH (SEQ_DEPTH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) u_table (
    .clk       (clk),
    .we_i      (exp_we && (state_q != ST_RUN)),
    .wr_test_i (exp_test),
    .wr_idx_i  (exp_idx),
    .wr_last_i (exp_last),
    .wr_addr_i (exp_addr),
    .wr_data_i (exp_data),
    .rd_test_i (test_q),
    .rd_idx_i  (ptr_q),
    .rd_last_o (ent_last),
    .rd_addr_o (ent_addr),
    .rd_data_o (ent_data)
  );

  // Store classification against the entry the pointer currently selects.
  // The last table position ends the sequence even without its last flag.
  assign hit         = memwrite && (ent_addr == dataadr) && (ent_data == writedata);
  assign miss        = memwrite && !hit;
  assign final_entry = ent_last || (ptr_q == IW'(SEQ_DEPTH - 1));
  assign complete    = hit && final_entry;
  assign expire      = (cycle_q == CNT_W'(TIMEOUT - 1));

  assign ptr_d   = ptr_q + IW'(1);
  assign cycle_d = cycle_q + CNT_W'(1);
  assign err_d   = (&err_q) ? err_q : err_q + CNT_W'(1);

  // Checker FSM with its pointer, counters and first-mismatch capture.
  // A completing match beats the timeout, which beats an ordered mismatch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ORDERED;
      test_q      <= '0;
      ptr_q       <= '0;
      cycle_q     <= '0;
      err_q       <= '0;
      bad_addr_q  <= '0;
      bad_data_q  <= '0;
      bad_seen_q  <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            state_q     <= ST_RUN;
            mode_q      <= mode_e'(mode);
            test_q      <= test_sel;
            ptr_q       <= '0;
            cycle_q     <= '0;
            err_q       <= '0;
            bad_addr_q  <= '0;
            bad_data_q  <= '0;
            bad_seen_q  <= 1'b0;
            timed_out_q <= 1'b0;
          end
        end
        ST_RUN: begin
          cycle_q <= cycle_d;
          if (hit) begin
            ptr_q <= ptr_d;
          end
          if (miss && !bad_seen_q) begin
            bad_addr_q <= dataadr;
            bad_data_q <= writedata;
            bad_seen_q <= 1'b1;
          end
          if (miss && (mode_q == MODE_LOOSE)) begin
            err_q <= err_d;
          end
          if (complete) begin
            state_q <= ST_PASS;
          end else if (expire) begin
            state_q     <= ST_FAIL;
            timed_out_q <= 1'b1;
          end else if (miss && (mode_q == MODE_ORDERED)) begin
            state_q <= ST_FAIL;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass        = (state_q == ST_PASS);
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_q;
  assign err_count   = err_q;
  assign bad_addr    = bad_addr_q;
  assign bad_data    = bad_data_q;

endmodule
